tile_painter: RTL and testbench



---
 rtl/tile_painter_if.sv | 23 ++
 rtl/tile_painter.sv | 192 +++++++++++++++++++
 tb/tb_tile_painter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tile_painter_if.sv
// rtl/tile_painter_if.sv - tile request handshake and 8-bit LCD write bus
interface tile_painter_if;
    logic       en_update;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj_code;
    logic       cmd_done;
    logic       busy;
    logic       lcd_csx;
    logic       lcd_dcx;
    logic       lcd_wrx;
    logic [7:0] lcd_d;

    modport master (
        output en_update, x, y, obj_code,
        input  cmd_done, busy, lcd_csx, lcd_dcx, lcd_wrx, lcd_d
    );

    modport slave (
        input  en_update, x, y, obj_code,
        output cmd_done, busy, lcd_csx, lcd_dcx, lcd_wrx, lcd_d
    );
endinterface

// File: rtl/tile_painter.sv
// rtl/tile_painter.sv - paints one grid cell as a TILE_PX square LCD write burst
module tile_painter #(
    parameter int TILE_PX   = 20,
    parameter int GRID_ROWS = 12
) (
    input  logic          clk,
    input  logic          nrst,
    tile_painter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PIX, S_DONE} state_t;

    localparam logic [15:0] TP       = 16'(TILE_PX);
    localparam logic [3:0]  ROWS     = 4'(GRID_ROWS);
    localparam logic [8:0]  LAST_PIX = 9'(TILE_PX * TILE_PX - 1);

    state_t      state_q, state_n;
    logic        phase_q, phase_n;
    logic [3:0]  hdr_q, hdr_n;
    logic [8:0]  pix_q, pix_n;
    logic        sel_q, sel_n;
    logic [3:0]  x_q, x_n, y_q, y_n;
    logic [2:0]  obj_q, obj_n;
    logic        csx_q, csx_n, dcx_q, dcx_n, wrx_q, wrx_n;
    logic [7:0]  d_q, d_n;
    logic        done_q, done_n, busy_q, busy_n;
    logic [15:0] colour;

    function automatic logic [15:0] colour_of(input logic [2:0] code);
        case (code)
            3'b000:  colour_of = 16'h0000;
            3'b001:  colour_of = 16'h03E0;
            3'b010:  colour_of = 16'h07E0;
            3'b011:  colour_of = 16'hF800;
            3'b100:  colour_of = 16'h001F;
            default: colour_of = 16'hF81F;
        endcase
    endfunction

    // Returns {dcx, byte} for header position idx of the address window setup.
    function automatic logic [8:0] hdr_byte(input logic [3:0] idx,
                                            input logic [3:0] cx,
                                            input logic [3:0] cy);
        logic [15:0] xs, xe, ys, ye;
        xs = 16'(cx) * TP;
        xe = xs + TP - 16'd1;
        ys = 16'(cy) * TP;
        ye = ys + TP - 16'd1;
        case (idx)
            4'd0:    hdr_byte = {1'b0, 8'h2A};
            4'd1:    hdr_byte = {1'b1, xs[15:8]};
            4'd2:    hdr_byte = {1'b1, xs[7:0]};
            4'd3:    hdr_byte = {1'b1, xe[15:8]};
            4'd4:    hdr_byte = {1'b1, xe[7:0]};
            4'd5:    hdr_byte = {1'b0, 8'h2B};
            4'd6:    hdr_byte = {1'b1, ys[15:8]};
            4'd7:    hdr_byte = {1'b1, ys[7:0]};
            4'd8:    hdr_byte = {1'b1, ye[15:8]};
            4'd9:    hdr_byte = {1'b1, ye[7:0]};
            4'd10:   hdr_byte = {1'b0, 8'h2C};
            default: hdr_byte = {1'b1, 8'h00};
        endcase
    endfunction

    assign colour = colour_of(obj_q);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            hdr_q   <= '0;
            pix_q   <= '0;
            sel_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            obj_q   <= '0;
            csx_q   <= 1'b1;
            dcx_q   <= 1'b1;
            wrx_q   <= 1'b1;
            d_q     <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            hdr_q   <= hdr_n;
            pix_q   <= pix_n;
            sel_q   <= sel_n;
            x_q     <= x_n;
            y_q     <= y_n;
            obj_q   <= obj_n;
            csx_q   <= csx_n;
            dcx_q   <= dcx_n;
            wrx_q   <= wrx_n;
            d_q     <= d_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
        end
    end

    // phase_q is the phase currently on the bus: 0 = strobe low, 1 = strobe high.
    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        hdr_n   = hdr_q;
        pix_n   = pix_q;
        sel_n   = sel_q;
        x_n     = x_q;
        y_n     = y_q;
        obj_n   = obj_q;
        csx_n   = csx_q;
        dcx_n   = dcx_q;
        wrx_n   = wrx_q;
        d_n     = d_q;
        done_n  = 1'b0;
        busy_n  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.en_update) begin
                    busy_n = 1'b1;
                    x_n    = bus.x;
                    y_n    = bus.y;
                    obj_n  = bus.obj_code;
                    if (bus.y < ROWS) begin
                        state_n = S_HDR;
                        hdr_n   = 4'd0;
                        phase_n = 1'b0;
                        csx_n   = 1'b0;
                        wrx_n   = 1'b0;
                        dcx_n   = 1'b0;
                        d_n     = 8'h2A;
                    end else begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (!phase_q) begin
                    phase_n = 1'b1;
                    wrx_n   = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    wrx_n   = 1'b0;
                    if (hdr_q == 4'd10) begin
                        state_n = S_PIX;
                        pix_n   = '0;
                        sel_n   = 1'b0;
                        dcx_n   = 1'b1;
                        d_n     = colour[15:8];
                    end else begin
                        hdr_n          = hdr_q + 4'd1;
                        {dcx_n, d_n}   = hdr_byte(hdr_q + 4'd1, x_q, y_q);
                    end
                end
            end
            S_PIX: begin
                if (!phase_q) begin
                    phase_n = 1'b1;
                    wrx_n   = 1'b1;
                end else if (sel_q && pix_q == LAST_PIX) begin
                    state_n = S_DONE;
                    csx_n   = 1'b1;
                    done_n  = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    wrx_n   = 1'b0;
                    if (!sel_q) begin
                        sel_n = 1'b1;
                        d_n   = colour[7:0];
                    end else begin
                        sel_n = 1'b0;
                        pix_n = pix_q + 9'd1;
                        d_n   = colour[15:8];
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                csx_n   = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.cmd_done = done_q;
    assign bus.busy     = busy_q;
    assign bus.lcd_csx  = csx_q;
    assign bus.lcd_dcx  = dcx_q;
    assign bus.lcd_wrx  = wrx_q;
    assign bus.lcd_d    = d_q;
endmodule

// File: tb/tb_tile_painter.sv
// tb/tb_tile_painter.sv - scoreboard bench for tile_painter
module tb_tile_painter;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    tile_painter_if bus();
    tile_painter #(.TILE_PX(20), .GRID_ROWS(12)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int rises    = 0;
    int dones    = 0;
    logic prev_wrx = 1'b1;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    // Every byte latched by the LCD (strobe rising) is popped and compared as {csx,dcx,d}.
    always @(negedge clk) begin : monitor
        logic [9:0] e;
        if (!nrst) begin
            prev_wrx = 1'b1;
        end else begin
            if (bus.lcd_wrx === 1'b1 && prev_wrx === 1'b0) begin
                rises++;
                if (exp_q.size() == 0) begin
                    check("byte_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("lcd_byte", {bus.lcd_csx, bus.lcd_dcx, bus.lcd_d}, e);
                end
            end
            prev_wrx = bus.lcd_wrx;
            if (bus.cmd_done === 1'b1) dones++;
        end
    end

    task automatic push_byte(input logic dcx, input logic [7:0] d);
        exp_q.push_back({1'b0, dcx, d});
    endtask

    task automatic push_tile(input int tx, input int ty, input int obj);
        logic [15:0] xs, xe, ys, ye, col;
        xs = 16'(tx * 20);
        xe = 16'(tx * 20 + 19);
        ys = 16'(ty * 20);
        ye = 16'(ty * 20 + 19);
        case (obj)
            0:       col = 16'h0000;
            1:       col = 16'h03E0;
            2:       col = 16'h07E0;
            3:       col = 16'hF800;
            4:       col = 16'h001F;
            default: col = 16'hF81F;
        endcase
        push_byte(1'b0, 8'h2A);
        push_byte(1'b1, xs[15:8]); push_byte(1'b1, xs[7:0]);
        push_byte(1'b1, xe[15:8]); push_byte(1'b1, xe[7:0]);
        push_byte(1'b0, 8'h2B);
        push_byte(1'b1, ys[15:8]); push_byte(1'b1, ys[7:0]);
        push_byte(1'b1, ye[15:8]); push_byte(1'b1, ye[7:0]);
        push_byte(1'b0, 8'h2C);
        for (int i = 0; i < 400; i++) begin
            push_byte(1'b1, col[15:8]);
            push_byte(1'b1, col[7:0]);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the accept edge.
    task automatic request(input int tx, input int ty, input int obj);
        bus.x         = 4'(tx);
        bus.y         = 4'(ty);
        bus.obj_code  = 3'(obj);
        bus.en_update = 1'b1;
        @(negedge clk);
        bus.en_update = 1'b0;
        bus.x         = 4'($urandom);
        bus.y         = 4'($urandom);
        bus.obj_code  = 3'($urandom);
    endtask

    task automatic check_phase_a(input string tag);
        check({tag, "_first_phase_a"},
              {bus.lcd_wrx, bus.lcd_csx, bus.lcd_dcx, bus.lcd_d, bus.busy},
              {1'b0, 1'b0, 1'b0, 8'h2A, 1'b1});
    endtask

    // c0 = negedges already elapsed since the first phase A cycle.
    task automatic finish_tile(input int r0, input int d0, input int c0, input string tag);
        int cyc = 0;
        for (int i = c0 + 1; i <= c0 + 3000; i++) begin
            @(negedge clk);
            if (bus.cmd_done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check({tag, "_done_latency"}, cyc, 1622);
        check({tag, "_byte_count"}, rises - r0, 811);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        // a request held during the DONE cycle must be ignored
        bus.x = 4'd3; bus.y = 4'd3; bus.obj_code = 3'd1;
        bus.en_update = 1'b1;
        @(negedge clk);
        bus.en_update = 1'b0;
        check({tag, "_done_pulse_idle"}, {bus.cmd_done, bus.busy, bus.lcd_csx, bus.lcd_wrx},
              {1'b0, 1'b0, 1'b1, 1'b1});
        check({tag, "_done_count"}, dones - d0, 1);
    endtask

    task automatic run_tile(input int tx, input int ty, input int obj, input string tag);
        int r0 = rises;
        int d0 = dones;
        push_tile(tx, ty, obj);
        request(tx, ty, obj);
        check_phase_a(tag);
        finish_tile(r0, d0, 0, tag);
    endtask

    initial begin
        int r0, d0, c;
        bus.en_update = 1'b0;
        bus.x = '0; bus.y = '0; bus.obj_code = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.lcd_csx, bus.lcd_wrx, bus.lcd_dcx, bus.lcd_d, bus.busy, bus.cmd_done},
              {1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
        nrst = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_no_strobes", rises, 0);
        check("idle_outputs", {bus.lcd_csx, bus.lcd_wrx, bus.busy, bus.cmd_done}, {1'b1, 1'b1, 1'b0, 1'b0});

        run_tile(4, 4, 3, "apple");
        run_tile(15, 11, 4, "border");

        // second request during the pixel phase is dropped
        r0 = rises; d0 = dones; c = 0;
        push_tile(2, 3, 1);
        request(2, 3, 1);
        check_phase_a("ignore");
        while (rises - r0 < 211 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        bus.x = 4'd7; bus.y = 4'd1; bus.obj_code = 3'd4;
        bus.en_update = 1'b1;
        @(negedge clk);
        c++;
        bus.en_update = 1'b0;
        finish_tile(r0, d0, c, "ignore");
        run_tile(0, 0, 2, "body_next");

        // out-of-range row: single-cycle busy and cmd_done, no bus traffic
        r0 = rises; d0 = dones;
        request(3, 12, 1);
        check("row12_done", {bus.cmd_done, bus.busy, bus.lcd_csx, bus.lcd_wrx}, {1'b1, 1'b1, 1'b1, 1'b1});
        @(negedge clk);
        check("row12_after", {bus.cmd_done, bus.busy}, {1'b0, 1'b0});
        check("row12_no_bytes", rises - r0, 0);
        check("row12_done_count", dones - d0, 1);

        // asynchronous reset during pixel 200
        r0 = rises; d0 = dones; c = 0;
        push_tile(1, 2, 5);
        request(1, 2, 5);
        check_phase_a("abort");
        while (rises - r0 < 411 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        #3 nrst = 1'b0;
        #1;
        check("abort_async_reset",
              {bus.lcd_csx, bus.lcd_wrx, bus.lcd_dcx, bus.lcd_d, bus.busy, bus.cmd_done},
              {1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
        exp_q.delete();
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", dones - d0, 0);
        run_tile(9, 5, 0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
